pool_collector: RTL and testbench
=================================

POOL_COLLECTOR -- requirements
Module: pool_collector

Interface
REQ-001 SHALL have parameter OUT_DIM, default 14, pooled feature-map side length (32-pixel image, 5x5 conv, 2x2 pool).
REQ-002 SHALL have parameter DW, default 9, sample width (signed two's complement).
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pool_in  input  DW  signed pooled sample from layer_1.
REQ-006 SHALL have port in_valid  input  1  pool_in qualifier, one sample per high cycle.
REQ-007 SHALL have port rd_en  input  1  host read strobe.
REQ-008 SHALL have port rd_addr  input  ceil(log2(OUT_DIM*OUT_DIM))  raster address (row*OUT_DIM+col) in the read bank.
REQ-009 SHALL have port rd_release  input  1  host pulse: finished with the current read bank.
REQ-010 SHALL have port rd_data  output  DW  signed read data.
REQ-011 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-012 SHALL have port rd_ready  output  1  a full bank is available for reading.
REQ-013 SHALL have port row_done  output  1  one-cycle pulse, last column of a row written.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse, last sample of a frame written.
REQ-015 SHALL have port overflow  output  1  sticky: a sample was dropped.

Function
REQ-016 SHALL hold two banks of OUT_DIM*OUT_DIM DW-bit words (ping-pong), each FREE or FULL.
REQ-017 SHALL use a writer FSM with states WRITE and STALL.
- WRITE: write bank is FREE.
- STALL: write bank is FULL.
REQ-018 In WRITE with in_valid high, SHALL store pool_in at (row,col) of the write bank, then increment col.
REQ-019 At col==OUT_DIM-1 SHALL wrap col to 0, increment row, and pulse row_done the following cycle.
REQ-020 At row==OUT_DIM-1 and col==OUT_DIM-1 SHALL do all of the following:
- pulse frame_done the following cycle (together with row_done);
- mark the write bank FULL;
- toggle the write bank;
- reset row and col to 0.
REQ-021 When the writer enters a bank that is FULL, the FSM SHALL go to STALL.
REQ-022 In STALL, samples with in_valid high SHALL be dropped, overflow SHALL be set, and row/col SHALL NOT advance.
REQ-023 STALL SHALL return to WRITE in the cycle after the write bank becomes FREE.
REQ-024 The read bank SHALL be the oldest FULL bank; rd_ready SHALL be high while any bank is FULL.
REQ-025 Read latency:
- rd_en high at cycle N with rd_ready high SHALL give rd_data = word[rd_addr] and rd_valid high at cycle N+1.
- rd_en with rd_ready low SHALL give rd_valid low.
- rd_data SHALL hold its value when rd_valid is low.
REQ-026 rd_release with rd_ready high SHALL mark the read bank FREE; rd_release with rd_ready low SHALL be ignored.
REQ-027 Simultaneous frame_done-marking and rd_release on different banks SHALL both take effect in the same cycle.
REQ-028 rd_addr >= OUT_DIM*OUT_DIM SHALL return rd_data = 0 with rd_valid high.
REQ-029 Samples SHALL be stored and returned bit-exact; no arithmetic and no sign change.

Reset
REQ-030 While reset is high, the block SHALL set:
- both banks FREE, write bank 0, row = col = 0, FSM in WRITE;
- rd_data 0, rd_valid 0, rd_ready 0, row_done 0, frame_done 0, overflow 0.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 A reset mid-frame SHALL discard the partial frame; the next sample after reset SHALL be written to bank 0, address 0.

Structure
REQ-033 OUT_DIM, DW, the address width function and the FSM state encoding SHALL live in a shared package, also used by layer_1.
REQ-034 A single sub-module, fm_bank (one synchronous-read RAM bank), SHALL be instantiated twice.

Verification
REQ-035 Stream 196 back-to-back samples 1..196 -> 14 row_done pulses, one frame_done one cycle after sample 196, rd_ready=1; reading addr 0/13/195 returns 1/14/196.
REQ-036 Stream samples with in_valid low on alternate cycles -> the same contents as REQ-035, with row_done spaced 28 cycles apart.
REQ-037 Stream 3 frames without rd_release -> frames 1 and 2 stored, all 196 samples of frame 3 dropped, overflow=1 from the first sample of frame 3.
REQ-038 Release one bank mid-frame-3 -> the writer resumes at addr 0 of the freed bank on the following valid sample; overflow stays 1.
REQ-039 Pulse reset after sample 50, then stream 1..196 -> bank 0 holds 1..196 and frame_done fires once.
REQ-040 Send signed samples -256 and 255 -> read back as 0x100 and 0x0FF.

Source files
------------

// File: rtl/pool_collector_pkg.sv
// Shared sizing, address-width helper and writer FSM encoding for the
// layer_1 / pool_collector feature-map path.
package pool_collector_pkg;

    localparam int unsigned OUT_DIM_DEF = 14;
    localparam int unsigned DW_DEF      = 9;

    localparam logic [0:0] ST_WRITE = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Bits needed to address n entries; never less than one.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/pool_collector_fm_bank.sv
// One feature-map bank: single write port, synchronous read whose output
// register only updates on a read enable so the data holds between reads.
module fm_bank #(
    parameter int unsigned DEPTH = 196,
    parameter int unsigned DW    = 9,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pool_collector.sv
// Ping-pong collector for pooled layer_1 samples: a raster writer fills one
// bank while the host reads the oldest full bank.
module pool_collector
    import pool_collector_pkg::*;
#(
    parameter int unsigned OUT_DIM = OUT_DIM_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic signed [DW-1:0]                      pool_in,
    input  logic                                      in_valid,
    input  logic                                      rd_en,
    input  logic [addr_w(OUT_DIM*OUT_DIM)-1:0]        rd_addr,
    input  logic                                      rd_release,
    output logic signed [DW-1:0]                      rd_data,
    output logic                                      rd_valid,
    output logic                                      rd_ready,
    output logic                                      row_done,
    output logic                                      frame_done,
    output logic                                      overflow
);

    localparam int unsigned DEPTH = OUT_DIM * OUT_DIM;
    localparam int unsigned AW    = addr_w(DEPTH);
    localparam int unsigned AW1   = AW + 1;
    localparam int unsigned CW    = addr_w(OUT_DIM);
    localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

    logic [0:0]    r_state;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [1:0]    r_bank_full;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_waddr;
    logic          r_rd_ready;
    logic          r_rd_valid;
    logic          r_rd_zero;
    logic          r_rd_sel;
    logic          r_row_done;
    logic          r_frame_done;
    logic          r_overflow;

    logic [0:0]    w_state_nxt;
    logic          w_wr_bank_nxt;
    logic          w_rd_bank_nxt;
    logic [1:0]    w_full_nxt;
    logic [CW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;
    logic [AW-1:0] w_waddr_nxt;
    logic          w_row_done_nxt;
    logic          w_frame_done_nxt;
    logic          w_overflow_nxt;
    logic          w_we;
    logic          w_release;
    logic          w_rd_hit;
    logic          w_rd_inrange;
    logic [DW-1:0] w_q0;
    logic [DW-1:0] w_q1;

    assign w_release    = rd_release && r_rd_ready;
    assign w_rd_hit     = rd_en && r_rd_ready;
    assign w_rd_inrange = {1'b0, rd_addr} < AW1'(DEPTH);

    // Writer FSM and bank bookkeeping; release and frame completion may land together.
    always_comb begin
        w_state_nxt      = r_state;
        w_full_nxt       = r_bank_full;
        w_wr_bank_nxt    = r_wr_bank;
        w_rd_bank_nxt    = r_rd_bank;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_waddr_nxt      = r_waddr;
        w_row_done_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_overflow_nxt   = r_overflow;
        w_we             = 1'b0;

        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt         = !r_rd_bank;
        end

        case (r_state)
            ST_WRITE: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    if (r_col == LAST) begin
                        w_col_nxt      = '0;
                        w_row_nxt      = r_row + CW'(1);
                        w_waddr_nxt    = r_waddr + AW'(1);
                        w_row_done_nxt = 1'b1;
                        if (r_row == LAST) begin
                            w_row_nxt             = '0;
                            w_waddr_nxt           = '0;
                            w_frame_done_nxt      = 1'b1;
                            w_full_nxt[r_wr_bank] = 1'b1;
                            w_wr_bank_nxt         = !r_wr_bank;
                            if (w_full_nxt[!r_wr_bank]) begin
                                w_state_nxt = ST_STALL;
                            end
                        end
                    end else begin
                        w_col_nxt   = r_col + CW'(1);
                        w_waddr_nxt = r_waddr + AW'(1);
                    end
                end
            end
            ST_STALL: begin
                if (in_valid) begin
                    w_overflow_nxt = 1'b1;
                end
                if (!w_full_nxt[r_wr_bank]) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: begin
                w_state_nxt = ST_WRITE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_WRITE;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_bank_full  <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_waddr      <= '0;
            r_rd_ready   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_zero    <= 1'b1;
            r_rd_sel     <= 1'b0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_bank    <= w_wr_bank_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_bank_full  <= w_full_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_waddr      <= w_waddr_nxt;
            r_rd_ready   <= |w_full_nxt;
            r_rd_valid   <= w_rd_hit;
            r_row_done   <= w_row_done_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overflow   <= w_overflow_nxt;
            // Out-of-range reads return zero; the select only moves on a real read.
            if (w_rd_hit) begin
                r_rd_zero <= !w_rd_inrange;
                r_rd_sel  <= r_rd_bank;
            end
        end
    end

    fm_bank #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_bank0 (
        .clk     (clk),
        .i_we    (w_we && !r_wr_bank),
        .i_waddr (r_waddr),
        .i_wdata (pool_in),
        .i_re    (w_rd_hit && w_rd_inrange && !r_rd_bank),
        .i_raddr (rd_addr),
        .o_rdata (w_q0)
    );

    fm_bank #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_bank1 (
        .clk     (clk),
        .i_we    (w_we && r_wr_bank),
        .i_waddr (r_waddr),
        .i_wdata (pool_in),
        .i_re    (w_rd_hit && w_rd_inrange && r_rd_bank),
        .i_raddr (rd_addr),
        .o_rdata (w_q1)
    );

    assign rd_data    = r_rd_zero ? '0 : (r_rd_sel ? w_q1 : w_q0);
    assign rd_valid   = r_rd_valid;
    assign rd_ready   = r_rd_ready;
    assign row_done   = r_row_done;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pool_collector.sv
// Directed/random bench for pool_collector against a queue-based model of
// the two-bank store: banks fill in arrival order and are read oldest first.
module tb_pool_collector;
    import pool_collector_pkg::*;

    localparam int unsigned D  = OUT_DIM_DEF;
    localparam int unsigned N  = D * D;
    localparam int unsigned W  = DW_DEF;
    localparam int unsigned AW = addr_w(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  pool_in = '0;
    logic          in_valid = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_release = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid, rd_ready, row_done, frame_done, overflow;

    pool_collector #(.OUT_DIM(D), .DW(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pool_in    (pool_in),
        .in_valid   (in_valid),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_release (rd_release),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .row_done   (row_done),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [W-1:0] m_mem [2][N];
    bit           m_full [2];
    int           m_wr, m_addr;
    int           m_q[$];
    bit           m_ovf;
    logic [W-1:0] m_rd_data;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, rows = 0, frames = 0, prev_row_cyc = -1;
    bit spacing_on = 1'b0;
    logic [W-1:0] v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit iv, input logic [W-1:0] val, input bit rel,
                        input bit ren, input logic [AW-1:0] addr);
        bit exp_rv, exp_row, exp_frame, rel_ok;
        int rb;
        exp_rv    = ren && (m_q.size() > 0);
        rel_ok    = rel && (m_q.size() > 0);
        exp_row   = 1'b0;
        exp_frame = 1'b0;
        if (exp_rv) m_rd_data = (addr < N) ? m_mem[m_q[0]][addr] : '0;
        if (iv) begin
            if (m_full[m_wr]) begin
                m_ovf = 1'b1;
            end else begin
                m_mem[m_wr][m_addr] = val;
                exp_row = (m_addr % D) == (D - 1);
                m_addr++;
                if (m_addr == N) begin
                    exp_frame    = 1'b1;
                    m_full[m_wr] = 1'b1;
                    m_q.push_back(m_wr);
                    m_wr   = 1 - m_wr;
                    m_addr = 0;
                end
            end
        end
        if (rel_ok) begin
            rb = m_q.pop_front();
            m_full[rb] = 1'b0;
        end

        in_valid = iv; pool_in = val; rd_release = rel; rd_en = ren; rd_addr = addr;
        @(posedge clk); #1;
        cyc++;

        check("row_done",   32'(row_done),   32'(exp_row));
        check("frame_done", 32'(frame_done), 32'(exp_frame));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("rd_ready",   32'(rd_ready),   32'(m_q.size() > 0));
        check("rd_valid",   32'(rd_valid),   32'(exp_rv));
        check("rd_data",    32'(rd_data),    32'(m_rd_data));
        if (row_done) begin
            rows++;
            if (spacing_on && prev_row_cyc >= 0) check("row_spacing", 32'(cyc - prev_row_cyc), 32'd28);
            prev_row_cyc = cyc;
        end
        if (frame_done) frames++;
    endtask

    task automatic send(input logic [W-1:0] val); step(1'b1, val, 1'b0, 1'b0, '0); endtask
    task automatic idle();                        step(1'b0, '0, 1'b0, 1'b0, '0); endtask
    task automatic rd(input int a);               step(1'b0, '0, 1'b0, 1'b1, AW'(a)); endtask
    task automatic rel();                         step(1'b0, '0, 1'b1, 1'b0, '0); endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        @(posedge clk); #1;
        cyc++;
        m_full[0] = 1'b0; m_full[1] = 1'b0; m_wr = 0; m_addr = 0;
        m_q.delete(); m_ovf = 1'b0; m_rd_data = '0;
        check("rst_rd_data",    32'(rd_data),    32'd0);
        check("rst_rd_valid",   32'(rd_valid),   32'd0);
        check("rst_rd_ready",   32'(rd_ready),   32'd0);
        check("rst_row_done",   32'(row_done),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        @(posedge clk); #1;
        cyc++;
        reset = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < int'(N); i++) send(W'($urandom));
    endtask

    initial begin
        do_reset();

        // Back-to-back counting frame
        rows = 0; frames = 0;
        for (int i = 1; i <= int'(N); i++) send(W'(i));
        check("b2b_rows", 32'(rows), 32'd14);
        check("b2b_frames", 32'(frames), 32'd1);
        rd(0);   check("b2b_addr0",   32'(rd_data), 32'd1);
        rd(13);  check("b2b_addr13",  32'(rd_data), 32'd14);
        rd(195); check("b2b_addr195", 32'(rd_data), 32'd196);
        rd(200); check("oor_valid", 32'(rd_valid), 32'd1);
        rel();

        // Half-rate input
        rows = 0; prev_row_cyc = -1; spacing_on = 1'b1;
        for (int i = 1; i <= int'(N); i++) begin send(W'(i)); idle(); end
        spacing_on = 1'b0;
        check("half_rows", 32'(rows), 32'd14);
        rd(0);   check("half_addr0",   32'(rd_data), 32'd1);
        rd(13);  check("half_addr13",  32'(rd_data), 32'd14);
        rd(195); check("half_addr195", 32'(rd_data), 32'd196);
        rel();

        // Random data with random gaps and random reads
        for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(W'($urandom));
        end
        for (int i = 0; i < 24; i++) rd(int'($urandom_range(0, 255)));
        rel();
        rd(5);
        rel();

        // Three frames without release, then release mid-stall
        do_reset();
        rand_frame();
        rand_frame();
        check("pre_ovf", 32'(overflow), 32'd0);
        rows = 0;
        send(W'($urandom));
        check("ovf_first", 32'(overflow), 32'd1);
        for (int i = 1; i < int'(N) + 50; i++) send(W'($urandom));
        check("stall_rows", 32'(rows), 32'd0);
        rd(0); rd(195);
        rel();
        v = W'($urandom);
        send(v);
        rand_frame();
        rd(0); rd(195);
        rel();
        rd(0);   check("resume_addr0", 32'(rd_data), 32'(v));
        rd(195);
        check("resume_ovf", 32'(overflow), 32'd1);
        rel();

        // Reset mid-frame
        do_reset();
        for (int i = 1; i <= 50; i++) send(W'(i));
        do_reset();
        frames = 0;
        for (int i = 1; i <= int'(N); i++) send(W'(i));
        idle();
        check("mid_rst_frames", 32'(frames), 32'd1);
        rd(0);   check("mid_rst_addr0",   32'(rd_data), 32'd1);
        rd(49);  check("mid_rst_addr49",  32'(rd_data), 32'd50);
        rd(50);  check("mid_rst_addr50",  32'(rd_data), 32'd51);
        rd(195); check("mid_rst_addr195", 32'(rd_data), 32'd196);
        rel();

        // Signed extremes
        do_reset();
        send(W'(-256));
        send(W'(255));
        for (int i = 2; i < int'(N); i++) send('0);
        rd(0); check("signed_min", 32'(rd_data), 32'h100);
        rd(1); check("signed_max", 32'(rd_data), 32'h0FF);
        rel();

        // Frame completion and release on the other bank in the same cycle
        rand_frame();
        for (int i = 0; i < int'(N) - 1; i++) send(W'($urandom));
        v = W'($urandom);
        step(1'b1, v, 1'b1, 1'b0, '0);
        check("simul_ready", 32'(rd_ready), 32'd1);
        send(W'($urandom));
        check("simul_ovf", 32'(overflow), 32'd0);
        rd(195); check("simul_last", 32'(rd_data), 32'(v));
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
